// File: rtl/countdown_ctrl_pkg.sv
// Shared definitions for the countdown controller: FSM state encoding and
// the BCD nibble clamp applied to the preset.
package countdown_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LOAD    = 3'd1,
      ST_ARMED   = 3'd2,
      ST_RUN     = 3'd3,
      ST_PAUSED  = 3'd4,
      ST_EXPIRED = 3'd5
   } state_e;

   localparam logic [3:0] BCD_MAX = 4'd9;

   // Non-decimal codes A..F are treated as the largest legal digit.
   function automatic logic [3:0] clamp_nibble(input logic [3:0] i_nib);
      return (i_nib > BCD_MAX) ? BCD_MAX : i_nib;
   endfunction

endpackage

// File: rtl/countdown_ctrl_tick_prescaler.sv
// Modulo-DIV cycle counter; tick is asserted combinationally during the
// enabled cycle in which the count sits at DIV-1 (the count wraps to 0 there).
module tick_prescaler #(
   parameter int DIV = 50000000
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int            CW   = (DIV > 2) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] r_count;

   // NOTE: rst is tested inside the clocked block, so it acts only on a clock
   // edge (synchronous); state is updated with <= so all flops see pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_count <= '0;
      end else if (clr) begin
         r_count <= '0;
      end else if (en) begin
         r_count <= (r_count == LAST) ? '0 : r_count + CW'(1);
      end
   end

   assign tick = en && !clr && (r_count == LAST);

endmodule

// File: rtl/countdown_ctrl.sv
// Master end of the BCD countdown borrow chain: loads clamped presets into the
// digits, issues prescaled borrow ticks to the LSD and detects expiry.
module countdown_ctrl
   import countdown_ctrl_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int TICK_DIV   = 50000000
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    load,
   input  logic                    start,
   input  logic                    pause,
   input  logic [4*NUM_DIGITS-1:0] preset_value,
   input  logic                    all_zero,
   output logic                    reconfig,
   output logic [4*NUM_DIGITS-1:0] starting_digits,
   output logic                    borrow_tick,
   output logic                    running,
   output logic                    expired
);

   localparam int W = 4 * NUM_DIGITS;

   state_e         r_state;
   state_e         w_next_state;
   logic [W-1:0]   r_digits;
   logic [W-1:0]   w_clamped;
   logic           r_borrow_tick;
   logic           w_load_req;
   logic           w_count_en;
   logic           w_tick;

   assign w_load_req = load && (r_state != ST_LOAD);

   // Only undisturbed RUN cycles advance the prescaler: a load, an expiry or a
   // pause seen in RUN freezes it, so ticks never fire below zero or while paused.
   assign w_count_en = (r_state == ST_RUN) && !w_load_req && !all_zero && !pause;

   tick_prescaler #(
      .DIV (TICK_DIV)
   ) u_prescaler (
      .clk  (clk),
      .rst  (rst),
      .en   (w_count_en),
      .clr  (w_load_req),
      .tick (w_tick)
   );

   always_comb begin
      w_clamped = '0;
      for (int d = 0; d < NUM_DIGITS; d++) begin
         w_clamped[4*d +: 4] = clamp_nibble(preset_value[4*d +: 4]);
      end
   end

   // NOTE: every output of this block is given a default before the case, so
   // no path leaves it unassigned and no latch is inferred.
   always_comb begin
      w_next_state = r_state;
      if (w_load_req) begin
         w_next_state = ST_LOAD;
      end else begin
         case (r_state)
            ST_IDLE:    w_next_state = ST_IDLE;
            ST_LOAD:    w_next_state = (r_digits == '0) ? ST_EXPIRED : ST_ARMED;
            ST_ARMED: begin
               // Digit flags are still settling from reconfig, so all_zero is not consulted.
               if (start && !pause) w_next_state = ST_RUN;
            end
            ST_RUN: begin
               if (all_zero)   w_next_state = ST_EXPIRED;
               else if (pause) w_next_state = ST_PAUSED;
            end
            ST_PAUSED: begin
               if (!pause) w_next_state = ST_RUN;
            end
            ST_EXPIRED: w_next_state = ST_EXPIRED;
            default:    w_next_state = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state       <= ST_IDLE;
         r_digits      <= '0;
         r_borrow_tick <= 1'b0;
      end else begin
         r_state       <= w_next_state;
         r_borrow_tick <= w_tick;
         if (w_load_req) r_digits <= w_clamped;
      end
   end

   assign reconfig        = (r_state == ST_LOAD);
   assign running         = (r_state == ST_RUN);
   assign expired         = (r_state == ST_EXPIRED);
   assign starting_digits = r_digits;
   assign borrow_tick     = r_borrow_tick;

endmodule
